// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Round-robin successor of an owner index; wraps explicitly so that
    // non-power-of-two requester counts never land on an unused index.
    function automatic int next_rr_ptr(input int owner, input int num_req);
        if (owner >= num_req - 1) begin
            return 0;
        end
        return owner + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_rr_arb_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    int               w_cand;
    logic [IDX_W-1:0] w_candIdx;

    // Scan every requester starting from rr_ptr and keep the first valid one
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        w_cand    = 0;
        w_candIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = int'(rr_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_candIdx = IDX_W'(w_cand);
            if (!gnt_any && req_valid[w_candIdx]) begin
                gnt_any = 1'b1;
                gnt_idx = w_candIdx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_rr_arb.sv
// Round-robin write arbiter sharing one sync FIFO write port among requesters.
module fifo_wr_rr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    import fifo_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_rrPtr;
    logic [CNT_W-1:0]     r_beatCnt;

    logic [IDX_W-1:0]      w_gntIdx;
    logic                  w_gntAny;
    logic                  w_inBurst;
    logic                  w_ownerValid;
    logic                  w_ownerLast;
    logic [DATA_WIDTH-1:0] w_ownerData;
    logic                  w_xfer;
    logic                  w_lastBeat;
    logic                  w_release;
    logic [IDX_W-1:0]      w_nextPtr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (r_rrPtr),
        .gnt_idx   (w_gntIdx),
        .gnt_any   (w_gntAny)
    );

    assign w_inBurst    = (r_state == ARB_BURST);
    assign w_ownerValid = req_valid[r_owner];
    assign w_ownerLast  = req_last[r_owner];
    assign w_ownerData  = req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
    assign w_xfer       = w_inBurst & w_ownerValid & ~fifo_full;
    assign w_lastBeat   = (r_beatCnt == CNT_W'(MAX_BURST - 1)) | w_ownerLast;
    // A full-stalled owner with valid high is neither transferring nor releasing
    assign w_release    = w_inBurst & ((w_xfer & w_lastBeat) | ~w_ownerValid);
    assign w_nextPtr    = IDX_W'(next_rr_ptr(int'(r_owner), NUM_REQ));

    // Grant/burst state machine with owner, round-robin pointer and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_owner   <= '0;
            r_rrPtr   <= '0;
            r_beatCnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_gntAny) begin
                        r_owner <= w_gntIdx;
                        r_state <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (w_release) begin
                        r_state   <= ARB_IDLE;
                        r_beatCnt <= '0;
                        r_rrPtr   <= w_nextPtr;
                    end else if (w_xfer) begin
                        r_beatCnt <= r_beatCnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Route the owner's stream onto the FIFO port; everything is quiet outside a burst
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        if (w_inBurst) begin
            req_ready[r_owner] = ~fifo_full;
            fifo_wr_en         = w_xfer;
            fifo_data_in       = w_ownerData;
        end
    end

    assign busy     = w_inBurst;
    assign grant_id = r_owner;

endmodule

// File: tb/tb_fifo_wr_rr_arb.sv
// Scoreboard bench for the round-robin FIFO write arbiter.
module tb_fifo_wr_rr_arb;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic [1:0]                    grant_id;
    logic                          busy;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0] srcQ [NUM_REQ][$];
    logic [7:0] expQ [NUM_REQ][$];
    int         grantLog[$];
    int         writeCycle[$];
    logic [7:0] writeData[$];
    bit         taken [NUM_REQ];

    int validRate = 100;
    int fullRate  = 0;
    bit fullForce = 1'b0;
    int cycleNum  = 0;

    int         modelPtr       = 0;
    int         curOwner       = 0;
    int         beatsInBurst   = 0;
    bit         prevBusy       = 1'b0;
    bit         expectIdleNext = 1'b0;
    bit         idleSnapValid  = 1'b0;
    logic [3:0] idleSnap       = '0;
    int         monExpGrant;
    bit         monXfer;
    bit         monEnd;
    logic [7:0] monExp;

    fifo_wr_rr_arb #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int req, input logic [7:0] data, input bit last);
        srcQ[req].push_back({last, data});
        expQ[req].push_back(data);
    endtask

    function automatic int firstFrom(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (ptr + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic clearLogs();
        grantLog.delete();
        writeCycle.delete();
        writeData.delete();
    endtask

    task automatic flushModel();
        for (int i = 0; i < NUM_REQ; i++) begin
            srcQ[i].delete();
            expQ[i].delete();
            taken[i] = 1'b0;
        end
        modelPtr       = 0;
        prevBusy       = 1'b0;
        idleSnapValid  = 1'b0;
        expectIdleNext = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int  n;
        bit  done;
        int  left;
        n    = 0;
        done = 1'b0;
        while (!done && n < maxCycles) begin
            @(negedge clk);
            n++;
            done = !busy;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (srcQ[i].size() != 0) done = 1'b0;
            end
        end
        checkOutput("drainDone", done, 1);
        left = 0;
        for (int i = 0; i < NUM_REQ; i++) left += expQ[i].size();
        checkOutput("beatsOutstanding", left, 0);
    endtask

    // Requesters: retire accepted beats, then present the next beat of each queue
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (taken[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
            taken[i] = 1'b0;
            if (srcQ[i].size() > 0) begin
                req_valid[i]                        = ($urandom_range(99) < validRate);
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = srcQ[i][0][7:0];
                req_last[i]                         = srcQ[i][0][8];
            end else begin
                req_valid[i]                        = 1'b0;
                req_last[i]                         = 1'b0;
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
        fifo_full = fullForce | ($urandom_range(99) < fullRate);
    end

    // Monitor: grant order, handshake rules and write-data scoreboard
    always @(negedge clk) begin
        cycleNum++;
        if (!rst_n) begin
            prevBusy       = 1'b0;
            idleSnapValid  = 1'b0;
            expectIdleNext = 1'b0;
        end else if (busy) begin
            if (expectIdleNext) begin
                checkOutput("bubbleAfterBurst", busy, 0);
            end else if (!prevBusy) begin
                monExpGrant = idleSnapValid ? firstFrom(idleSnap, modelPtr) : -1;
                checkOutput("grantId", grant_id, monExpGrant);
                curOwner     = (monExpGrant >= 0) ? monExpGrant : int'(grant_id);
                beatsInBurst = 0;
                grantLog.push_back(int'(grant_id));
            end
            idleSnapValid = 1'b0;
            checkOutput("ownerHeld", grant_id, curOwner);
            monXfer = req_valid[curOwner] && !fifo_full;
            checkOutput("wrEn", fifo_wr_en, monXfer);
            checkOutput("reqReady", req_ready, fifo_full ? 0 : (1 << curOwner));
            if (fifo_wr_en) begin
                if (expQ[curOwner].size() == 0) begin
                    checkOutput("unexpectedWrite", 1, 0);
                end else begin
                    monExp = expQ[curOwner].pop_front();
                    checkOutput("wrData", fifo_data_in, monExp);
                end
                writeCycle.push_back(cycleNum);
                writeData.push_back(fifo_data_in);
            end
            monEnd = (monXfer && (beatsInBurst + 1 == MAX_BURST || req_last[curOwner]))
                     || !req_valid[curOwner];
            if (monXfer) beatsInBurst++;
            if (monEnd) modelPtr = (curOwner + 1) % NUM_REQ;
            expectIdleNext = monEnd;
            for (int i = 0; i < NUM_REQ; i++) taken[i] = req_valid[i] && req_ready[i];
        end else begin
            if (idleSnapValid) checkOutput("grantLatency", busy, 1);
            checkOutput("idleWrEn", fifo_wr_en, 0);
            checkOutput("idleReady", req_ready, 0);
            checkOutput("idleData", fifo_data_in, 0);
            idleSnap       = req_valid;
            idleSnapValid  = |req_valid;
            expectIdleNext = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) taken[i] = 1'b0;
        end
        prevBusy = busy;
    end

    // Directed scenarios, randomized traffic, drain and summary
    initial begin
        int n;
        int r;
        int len;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstWrEn", fifo_wr_en, 0);
        checkOutput("rstReady", req_ready, 0);
        checkOutput("rstGrant", grant_id, 0);
        checkOutput("rstData", fifo_data_in, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // single requester, 6 beats split 4 + 2 with one idle bubble
        clearLogs();
        for (int i = 0; i < 6; i++) applyStimulus(0, 8'(8'h10 + i), 1'b0);
        waitIdle(100);
        checkOutput("t1Writes", writeData.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < writeData.size()) checkOutput("t1Data", writeData[i], 8'h10 + i);
        end
        if (writeCycle.size() >= 5) checkOutput("t1Bubble", writeCycle[4] - writeCycle[3], 2);
        checkOutput("t1Bursts", grantLog.size(), 2);

        // move the pointer back to 0 via a one-beat req3 burst
        applyStimulus(3, 8'h3F, 1'b0);
        waitIdle(50);

        // all four requesters continuously valid
        clearLogs();
        for (int rq = 0; rq < NUM_REQ; rq++) begin
            for (int k = 0; k < 8; k++) applyStimulus(rq, 8'(rq * 16 + k), 1'b0);
        end
        waitIdle(300);
        checkOutput("t2Bursts", grantLog.size(), 8);
        for (int i = 0; i < 5; i++) begin
            if (i < grantLog.size()) checkOutput("t2GrantSeq", grantLog[i], i % NUM_REQ);
        end
        checkOutput("t2Writes", writeCycle.size(), 32);
        for (int k = 0; k < 31; k++) begin
            if (k + 1 < writeCycle.size())
                checkOutput("t2WrPattern", writeCycle[k+1] - writeCycle[k], (k % 4 == 3) ? 2 : 1);
        end

        // req1 ends its packet on the 2nd beat, req2 follows
        clearLogs();
        applyStimulus(1, 8'hA0, 1'b0);
        applyStimulus(1, 8'hA1, 1'b1);
        applyStimulus(1, 8'hA2, 1'b0);
        applyStimulus(2, 8'hB0, 1'b0);
        applyStimulus(2, 8'hB1, 1'b0);
        waitIdle(100);
        checkOutput("t3Grant0", grantLog.size() > 0 ? grantLog[0] : -1, 1);
        checkOutput("t3Grant1", grantLog.size() > 1 ? grantLog[1] : -1, 2);
        if (writeCycle.size() >= 3) checkOutput("t3BurstEnd", writeCycle[2] - writeCycle[1], 2);

        // FIFO full for 3 cycles after the first beat of a burst
        clearLogs();
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'(8'hC0 + i), 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_wr_en && n < 50);
        checkOutput("t4FirstBeat", fifo_wr_en, 1);
        fullForce = 1'b1;
        repeat (3) @(negedge clk);
        fullForce = 1'b0;
        waitIdle(100);
        checkOutput("t4Writes", writeData.size(), 4);
        checkOutput("t4Bursts", grantLog.size(), 1);
        if (writeCycle.size() >= 2) checkOutput("t4Stall", writeCycle[1] - writeCycle[0], 4);

        // req3 goes idle after one beat, req0 is next
        clearLogs();
        applyStimulus(3, 8'h50, 1'b0);
        applyStimulus(0, 8'h60, 1'b0);
        applyStimulus(0, 8'h61, 1'b0);
        waitIdle(100);
        checkOutput("t5Grant0", grantLog.size() > 0 ? grantLog[0] : -1, 3);
        checkOutput("t5Grant1", grantLog.size() > 1 ? grantLog[1] : -1, 0);

        // asynchronous reset in the middle of a burst
        clearLogs();
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'hD0 + i), 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_wr_en && n < 50);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6Busy", busy, 0);
        checkOutput("t6WrEn", fifo_wr_en, 0);
        checkOutput("t6Ready", req_ready, 0);
        checkOutput("t6Grant", grant_id, 0);
        checkOutput("t6Data", fifo_data_in, 0);
        flushModel();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        clearLogs();
        applyStimulus(0, 8'hE0, 1'b0);
        applyStimulus(0, 8'hE1, 1'b1);
        applyStimulus(2, 8'hF0, 1'b0);
        applyStimulus(2, 8'hF1, 1'b1);
        waitIdle(100);
        checkOutput("t6Grant0", grantLog.size() > 0 ? grantLog[0] : -1, 0);
        checkOutput("t6Grant1", grantLog.size() > 1 ? grantLog[1] : -1, 2);

        // randomized traffic with gaps, packet ends and FIFO back-pressure
        validRate = 85;
        fullRate  = 20;
        repeat (600) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                r   = $urandom_range(NUM_REQ - 1);
                len = $urandom_range(6, 1);
                for (int k = 0; k < len; k++)
                    applyStimulus(r, 8'($urandom), (k == len - 1) && ($urandom_range(1) == 1));
            end
        end
        validRate = 100;
        fullRate  = 0;
        waitIdle(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
